// File: rtl/rsa_job_arbiter.sv
// ---------------------------------------------------------------------------
// rsa_job_arbiter
//
// Purpose:
//   Shares a single RSA core between two requesters (0 = SPI host,
//   1 = self-test) using a four-phase req/gnt/done handshake. A job is
//   granted, its operands are registered into the core, the core is
//   released from reset until it signals end-of-computation, and the result
//   is captured and held for the granted requester. Ties are resolved
//   round-robin. A requester that drops req before done aborts its job.
//
// Optional feature (macro RSA_ARB_TIMEOUT_EN):
//   Defined:   an 8-bit RUN counter aborts a job that has not finished after
//              200 RUN cycles. The job completes with result = 0 and the
//              granted err set.
//   Undefined: RUN waits indefinitely and err0/err1 are tied low.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset (overrides ena)
//   ena          global enable; all state holds while low
//   req0/req1    job requests
//   op0_*/op1_*  per-requester operands (msg, mod, exp), 8 bits each
//   gnt0/gnt1    requester currently owns the core
//   done0/done1  result valid for the granted requester
//   err0/err1    job ended by timeout; valid while the matching done is high
//   result       captured core result
//   core_rstb    active-low core reset; low whenever no job runs
//   core_msg/mod/exp  registered operands to the core
//   core_eoc     core end-of-computation level
//   core_result  core result, valid while core_eoc is high
// ---------------------------------------------------------------------------
module rsa_job_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] op0_msg,
    input  logic [7:0] op0_mod,
    input  logic [7:0] op0_exp,
    input  logic [7:0] op1_msg,
    input  logic [7:0] op1_mod,
    input  logic [7:0] op1_exp,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] result,
    output logic       core_rstb,
    output logic [7:0] core_msg,
    output logic [7:0] core_mod,
    output logic [7:0] core_exp,
    input  logic       core_eoc,
    input  logic [7:0] core_result
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        RELEASE
    } state_t;

    state_t state;
    logic   sel;        // requester owning the current job
    logic   last;       // requester granted most recently (completed job)
    logic   winner;
    logic   sel_req;

    // On a tie the requester that was not granted last wins; otherwise the
    // only active requester wins.
    assign winner  = (req0 && req1) ? ~last : req1;

    // The owning requester's req; dropping it ends or aborts the job.
    assign sel_req = sel ? req1 : req0;

`ifdef RSA_ARB_TIMEOUT_EN
    logic [7:0] run_cnt;
    logic       err0_q;
    logic       err1_q;

    assign err0 = err0_q;
    assign err1 = err1_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            result    <= 8'd0;
            core_rstb <= 1'b0;
            core_msg  <= 8'd0;
            core_mod  <= 8'd0;
            core_exp  <= 8'd0;
`ifdef RSA_ARB_TIMEOUT_EN
            run_cnt   <= 8'd0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: begin
                    // Grant and operand capture happen together so that
                    // gnt and core_* are both valid for the whole LOAD cycle.
                    if (req0 || req1) begin
                        sel      <= winner;
                        gnt0     <= ~winner;
                        gnt1     <= winner;
                        core_msg <= winner ? op1_msg : op0_msg;
                        core_mod <= winner ? op1_mod : op0_mod;
                        core_exp <= winner ? op1_exp : op0_exp;
                        state    <= LOAD;
                    end
                end

                LOAD: begin
                    if (!sel_req) begin
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        core_rstb <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        core_rstb <= 1'b1;
`ifdef RSA_ARB_TIMEOUT_EN
                        run_cnt   <= 8'd0;
`endif
                        state     <= RUN;
                    end
                end

                RUN: begin
                    // An abort takes priority over a simultaneous eoc so an
                    // abandoned job never disturbs the held result.
                    if (!sel_req) begin
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        core_rstb <= 1'b0;
                        state     <= IDLE;
                    end else if (core_eoc) begin
                        // Latch while eoc is still high; the core is put
                        // back into reset on the same edge.
                        result    <= core_result;
                        core_rstb <= 1'b0;
                        state     <= CAPTURE;
                    end
`ifdef RSA_ARB_TIMEOUT_EN
                    else if (run_cnt + 8'd1 == 8'd200) begin
                        // 200th RUN cycle without eoc: finish with an error.
                        result    <= 8'd0;
                        core_rstb <= 1'b0;
                        done0     <= ~sel;
                        done1     <= sel;
                        err0_q    <= ~sel;
                        err1_q    <= sel;
                        state     <= RELEASE;
                    end else begin
                        run_cnt   <= run_cnt + 8'd1;
                    end
`endif
                end

                CAPTURE: begin
                    if (!sel_req) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done0 <= ~sel;
                        done1 <= sel;
                        state <= RELEASE;
                    end
                end

                RELEASE: begin
                    // Done falls here; returning to IDLE guarantees at least
                    // one cycle before the next grant can be issued.
                    if (!sel_req) begin
                        gnt0   <= 1'b0;
                        gnt1   <= 1'b0;
                        done0  <= 1'b0;
                        done1  <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
                        err0_q <= 1'b0;
                        err1_q <= 1'b0;
`endif
                        last   <= sel;
                        state  <= IDLE;
                    end
                end

                default: begin
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    done0     <= 1'b0;
                    done1     <= 1'b0;
                    core_rstb <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rsa_job_arbiter
//
// Drives rsa_job_arbiter with directed and randomized jobs. A simple RSA
// core stand-in raises eoc a programmable number of cycles after core_rstb
// goes high. Expected grants, operands, results and latencies come from a
// transaction-level model of the arbitration rules (round-robin on ties,
// four-phase handshake).
// ---------------------------------------------------------------------------
module tb_rsa_job_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       req0;
    logic       req1;
    logic [7:0] op0_msg, op0_mod, op0_exp;
    logic [7:0] op1_msg, op1_mod, op1_exp;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0] result;
    logic       core_rstb;
    logic [7:0] core_msg, core_mod, core_exp;
    logic       core_eoc = 1'b0;
    logic [7:0] core_result = 8'd0;

    int checks   = 0;
    int failures = 0;

    // Core stand-in configuration
    int         core_lat = 1000;
    logic [7:0] core_res_val = 8'd0;
    int         core_cnt = 0;

    // Model state: requester granted on the most recent completed job
    bit lastGnt = 1'b1;

    rsa_job_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .req0       (req0),
        .req1       (req1),
        .op0_msg    (op0_msg),
        .op0_mod    (op0_mod),
        .op0_exp    (op0_exp),
        .op1_msg    (op1_msg),
        .op1_mod    (op1_mod),
        .op1_exp    (op1_exp),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .err0       (err0),
        .err1       (err1),
        .result     (result),
        .core_rstb  (core_rstb),
        .core_msg   (core_msg),
        .core_mod   (core_mod),
        .core_exp   (core_exp),
        .core_eoc   (core_eoc),
        .core_result(core_result)
    );

    always #5 clk = ~clk;

    // Core stand-in: counts cycles out of reset, then holds eoc and result.
    always @(negedge clk) begin
        if (core_rstb !== 1'b1) begin
            core_cnt    = 0;
            core_eoc    = 1'b0;
            core_result = 8'd0;
        end else begin
            core_cnt = core_cnt + 1;
            if (core_cnt >= core_lat) begin
                core_eoc    = 1'b1;
                core_result = core_res_val;
            end
        end
    end

    // One clock step; outputs are sampled and inputs driven 1 time unit
    // after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic randomOperands();
        op0_msg = 8'($urandom); op0_mod = 8'($urandom); op0_exp = 8'($urandom);
        op1_msg = 8'($urandom); op1_mod = 8'($urandom); op1_exp = 8'($urandom);
    endtask

    // One complete job. The caller has set the operands; r0/r1 are the
    // requests active at the grant edge.
    task automatic doJob(input bit r0, input bit r1, input int lat,
                         input logic [7:0] res, input bit enaStep);
        bit         w;
        int         n;
        bit         conflict;
        logic [7:0] em, eo, ee;
        logic       dw;

        if (r0 && r1) begin
            if (lastGnt) w = 1'b0;
            else         w = 1'b1;
        end else if (r0) begin
            w = 1'b0;
        end else begin
            w = 1'b1;
        end
        em = w ? op1_msg : op0_msg;
        eo = w ? op1_mod : op0_mod;
        ee = w ? op1_exp : op0_exp;

        core_lat     = lat;
        core_res_val = res;
        req0 = r0;
        req1 = r1;

        applyStimulus();
        checkOutput("grant_gnt0", gnt0, !w);
        checkOutput("grant_gnt1", gnt1, w);
        checkOutput("load_core_msg", core_msg, em);
        checkOutput("load_core_mod", core_mod, eo);
        checkOutput("load_core_exp", core_exp, ee);
        checkOutput("load_core_rstb", core_rstb, 0);

        // Operands move after the grant; core_* must not follow.
        randomOperands();

        applyStimulus();
        checkOutput("run_core_rstb", core_rstb, 1);

        n = 0;
        conflict = 1'b0;
        dw = w ? done1 : done0;
        while (dw !== 1'b1 && n < lat + 20) begin
            if ((gnt0 && gnt1) || (done0 && done1) || (w ? gnt0 : gnt1))
                conflict = 1'b1;
            applyStimulus();
            n++;
            dw = w ? done1 : done0;
        end
        checkOutput("done_latency", n, lat + 1);
        checkOutput("exclusive_while_running", conflict, 0);
        checkOutput("result", result, res);
        checkOutput("err_on_success", w ? err1 : err0, 0);
        checkOutput("other_done_low", w ? done0 : done1, 0);
        checkOutput("hold_core_msg", core_msg, em);
        checkOutput("hold_core_exp", core_exp, ee);

        repeat ($urandom_range(0, 3)) applyStimulus();
        checkOutput("done_held", w ? done1 : done0, 1);

        if (w) req1 = 1'b0;
        else   req0 = 1'b0;
        if (enaStep) begin
            ena = 1'b0;
            applyStimulus();
            applyStimulus();
            checkOutput("ena_low_done_hold", w ? done1 : done0, 1);
            ena = 1'b1;
        end
        applyStimulus();
        checkOutput("done_fall", w ? done1 : done0, 0);
        checkOutput("gnt_fall_gnt0", gnt0, 0);
        checkOutput("gnt_fall_gnt1", gnt1, 0);
        lastGnt = w;
    endtask

    initial begin
        bit   p0, p1, r0, r1;
        int   n;

        // Reset with ena low: reset must still take effect.
        rst = 1'b1; ena = 1'b0; req0 = 1'b0; req1 = 1'b0;
        randomOperands();
        applyStimulus();
        applyStimulus();
        checkOutput("reset_gnt", {gnt1, gnt0}, 0);
        checkOutput("reset_done", {done1, done0}, 0);
        checkOutput("reset_err", {err1, err0}, 0);
        checkOutput("reset_core_rstb", core_rstb, 0);
        checkOutput("reset_core_ops", {core_msg, core_mod, core_exp}, 0);
        checkOutput("reset_result", result, 0);
        rst = 1'b0; ena = 1'b1;
        applyStimulus();
        checkOutput("idle_no_grant", {gnt1, gnt0}, 0);

        // Single job from requester 0: msg=4 mod=7 exp=3, result 1 after 40.
        op0_msg = 8'd4; op0_mod = 8'd7; op0_exp = 8'd3;
        doJob(1'b1, 1'b0, 40, 8'd1, 1'b0);

        // Tie after reset-like history (last = 0 now), so set up a fresh
        // tie pair: first tie goes to 1 here, then 0 wins the next tie.
        randomOperands();
        doJob(1'b1, 1'b1, 5, 8'hA5, 1'b0);
        // req0 is still pending from the tie; raising req1 again ties.
        doJob(1'b1, 1'b1, 7, 8'h3C, 1'b1);

        // Randomized jobs; the loser of a tie keeps its request pending.
        p0 = 1'b0; p1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            r0 = p0 | 1'($urandom);
            r1 = p1 | 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            randomOperands();
            doJob(r0, r1, $urandom_range(1, 30), 8'($urandom), 1'($urandom));
            p0 = req0;
            p1 = req1;
        end
        while (req0 || req1) begin
            randomOperands();
            doJob(req0, req1, 3, 8'h5A, 1'b0);
        end

        // Abort: req0 drops during RUN while req1 waits.
        core_lat = 100000;
        req0 = 1'b1;
        applyStimulus();
        checkOutput("abort_gnt0", gnt0, 1);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        req1 = 1'b1;
        applyStimulus();
        req0 = 1'b0;
        applyStimulus();
        checkOutput("abort_core_rstb", core_rstb, 0);
        checkOutput("abort_gnt", {gnt1, gnt0}, 0);
        checkOutput("abort_no_done", {done1, done0}, 0);
        randomOperands();
        doJob(1'b0, 1'b1, 9, 8'hC3, 1'b0);

        // Reset pulsed during RUN.
        core_lat = 100000;
        req0 = 1'b1;
        repeat (4) applyStimulus();
        checkOutput("pre_reset_running", core_rstb, 1);
        rst = 1'b1;
        req0 = 1'b0;
        applyStimulus();
        checkOutput("midrst_gnt", {gnt1, gnt0}, 0);
        checkOutput("midrst_done", {done1, done0}, 0);
        checkOutput("midrst_core_rstb", core_rstb, 0);
        checkOutput("midrst_core_ops", {core_msg, core_mod, core_exp}, 0);
        checkOutput("midrst_result", result, 0);
        rst = 1'b0;
        lastGnt = 1'b1;
        applyStimulus();
        checkOutput("post_reset_idle", {gnt1, gnt0}, 0);
        randomOperands();
        doJob(1'b1, 1'b0, 12, 8'h77, 1'b0);

        // Core that never finishes.
        core_lat = 100000;
        req0 = 1'b1;
        applyStimulus();
        applyStimulus();
`ifdef RSA_ARB_TIMEOUT_EN
        n = 0;
        while (done0 !== 1'b1 && n < 260) begin
            applyStimulus();
            n++;
        end
        checkOutput("timeout_cycles", n, 200);
        checkOutput("timeout_done0", done0, 1);
        checkOutput("timeout_err0", err0, 1);
        checkOutput("timeout_result", result, 0);
        req0 = 1'b0;
        applyStimulus();
        checkOutput("timeout_release", {done0, err0, gnt0}, 0);
        lastGnt = 1'b0;
`else
        n = 0;
        repeat (230) begin
            if (done0 === 1'b1 || err0 !== 1'b0) n++;
            applyStimulus();
        end
        checkOutput("no_timeout_done_or_err", n, 0);
        checkOutput("no_timeout_still_running", core_rstb, 1);
        req0 = 1'b0;
        applyStimulus();
        checkOutput("no_timeout_abort", {core_rstb, gnt0, done0}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsa_job_arbiter.md
RSA_JOB_ARBITER -- requirements
Module: rsa_job_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port ena, input, 1 bit: global enable; when low, all state holds and outputs hold.
REQ-004 SHALL have ports req0 and req1, input, 1 bit each: job request from requester 0 (SPI host) and requester 1 (self-test).
REQ-005 SHALL have ports op0_msg, op0_mod, op0_exp, op1_msg, op1_mod, op1_exp, input, 8 bits each: operands held stable by each requester while its req is high.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 bit each: requester owns the core.
REQ-007 SHALL have ports done0 and done1, output, 1 bit each: result valid for the granted requester.
REQ-008 SHALL have ports err0 and err1, output, 1 bit each: job aborted by timeout; valid while the matching done is high.
REQ-009 SHALL have port result, output, 8 bits: captured core result.
REQ-010 SHALL have port core_rstb, output, 1 bit: active-low reset to the RSA core; low whenever no job runs.
REQ-011 SHALL have ports core_msg, core_mod, core_exp, output, 8 bits each: registered operands to the core.
REQ-012 SHALL have port core_eoc, input, 1 bit: core end-of-computation level.
REQ-013 SHALL have port core_result, input, 8 bits: core result, valid while core_eoc is high.

Function
REQ-014 SHALL implement the states IDLE, LOAD, RUN, CAPTURE and RELEASE.
REQ-015 IDLE: if any req is high, SHALL pick a winner and go to LOAD; on a tie, the winner SHALL be the requester not granted last (round-robin); after reset, requester 0 wins the first tie.
REQ-016 LOAD (1 cycle): SHALL register the winner's operands into core_*, assert its gnt, keep core_rstb low, then go to RUN.
REQ-017 RUN: core_rstb SHALL be high; when core_eoc is high, SHALL go to CAPTURE.
REQ-018 CAPTURE (1 cycle): SHALL latch core_result into result, drive core_rstb low, then go to RELEASE.
REQ-019 RELEASE: done of the granted requester SHALL be high; when its req goes low, SHALL clear done, err and gnt, update the last-granted flag and return to IDLE the next cycle.
REQ-020 Handshake SHALL be four-phase: req high -> gnt -> done -> req low -> done low; a new grant SHALL NOT issue in the same cycle that done falls.
REQ-021 A requester that drops req before done SHALL abort the job: core_rstb low, gnt low, no done, return to IDLE next cycle; the other requester is then eligible.
REQ-022 Operand changes during LOAD..RELEASE SHALL NOT affect core_*.
REQ-023 At most one gnt and at most one done SHALL be high in any cycle.
REQ-024 result SHALL hold its value until the next CAPTURE or timeout.

Reset
REQ-025 With rst high at a clock edge, the block SHALL enter IDLE and drive gnt*, done*, err* = 0, core_rstb = 0, core_* = 0 and result = 0, with last-granted = requester 1; rst SHALL override ena.
REQ-026 Reset mid-job SHALL abandon the job without asserting done.

Configuration
REQ-027 Macro RSA_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering RUN and increment each RUN cycle; at count 200 without core_eoc, the block SHALL set result = 0 and the granted err = 1 and go to RELEASE, skipping CAPTURE.
REQ-028 Macro RSA_ARB_TIMEOUT_EN undefined: no counter SHALL exist, RUN SHALL wait indefinitely, and err0/err1 SHALL be tied to 0.

Verification
REQ-029 req0 only, msg=4, mod=7, exp=3, core model raises eoc with result 1 after 40 cycles -> gnt0 one cycle after req0, done0 with result=1, done0 low one cycle after req0 drops.
REQ-030 req0 and req1 raised in the same cycle after reset -> gnt0 first; on the next tie, gnt1.
REQ-031 req1 held while job 0 runs -> gnt1 only after done0 falls, never overlapping gnt0.
REQ-032 req0 dropped during RUN -> core_rstb low next cycle, no done0, pending req1 granted.
REQ-033 rst pulsed during RUN -> all outputs 0 and IDLE next cycle; a subsequent req0 completes normally.
REQ-034 RSA_ARB_TIMEOUT_EN defined and core_eoc never set -> done0=1, err0=1, result=0 after 200 RUN cycles.
